// File: rtl/repair_ctrl_ngroup_if.sv
// Sideband/control bundle between the MBTRAIN REPAIR controller and its environment.
// Ports: i_* are environment-driven (enable, local mask, received sideband message/mask/strobe, busy-fall pulse);
//        o_* are controller-driven (outgoing message strobe/code/mask, latched remote mask, ack, timeout).
interface repair_ctrl_ngroup_if #(
  parameter int NUM_GROUPS = 2,
  parameter int MSG_W      = 4
);
  logic                  i_en;
  logic [NUM_GROUPS-1:0] i_lanes_functional;
  logic [MSG_W-1:0]      i_sideband_message;
  logic [NUM_GROUPS-1:0] i_sideband_data_lanes_encoding;
  logic                  i_sideband_valid;
  logic                  i_falling_edge_busy;

  logic                  o_valid;
  logic [MSG_W-1:0]      o_sideband_message;
  logic [NUM_GROUPS-1:0] o_sideband_data_lanes_encoding;
  logic [NUM_GROUPS-1:0] o_remote_partner_lanes_result;
  logic                  o_test_ack;
  logic                  o_timeout;

  // Environment / sideband side.
  modport master (
    output i_en, i_lanes_functional, i_sideband_message,
           i_sideband_data_lanes_encoding, i_sideband_valid, i_falling_edge_busy,
    input  o_valid, o_sideband_message, o_sideband_data_lanes_encoding,
           o_remote_partner_lanes_result, o_test_ack, o_timeout
  );

  // Repair controller side.
  modport slave (
    input  i_en, i_lanes_functional, i_sideband_message,
           i_sideband_data_lanes_encoding, i_sideband_valid, i_falling_edge_busy,
    output o_valid, o_sideband_message, o_sideband_data_lanes_encoding,
           o_remote_partner_lanes_result, o_test_ack, o_timeout
  );
endinterface

// File: rtl/repair_ctrl_ngroup.sv
// MBTRAIN REPAIR handshake controller: local requester FSM plus remote responder sharing one sideband port.
// Ports: clk, rst_n (async active-low), bus (slave modport): enable, masks, sideband rx/tx, busy-fall, ack, timeout.
// One message issues per cycle when nothing is in flight (or busy falls that cycle); responses beat requests.
module repair_ctrl_ngroup #(
  parameter int NUM_GROUPS     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MSG_W          = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  repair_ctrl_ngroup_if.slave  bus
);

  localparam logic [MSG_W-1:0] M_START_REQ    = MSG_W'(1);
  localparam logic [MSG_W-1:0] M_START_RESP   = MSG_W'(2);
  localparam logic [MSG_W-1:0] M_DEGRADE_REQ  = MSG_W'(3);
  localparam logic [MSG_W-1:0] M_DEGRADE_RESP = MSG_W'(4);
  localparam logic [MSG_W-1:0] M_END_REQ      = MSG_W'(5);
  localparam logic [MSG_W-1:0] M_END_RESP     = MSG_W'(6);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_START, S_WAIT_START, S_SEND_DEG, S_WAIT_DEG,
    S_SEND_END, S_WAIT_END, S_TX_DONE, S_TIMEOUT
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_GROUPS-1:0] local_q, local_d;
  logic [NUM_GROUPS-1:0] remote_q, remote_d;
  logic                  start_pend_q, deg_pend_q, end_pend_q;
  logic                  start_pend_d, deg_pend_d, end_pend_d;
  logic                  rx_done_q, rx_done_d;
  logic                  in_flight_q, in_flight_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  valid_q;
  logic [MSG_W-1:0]      msg_q;
  logic [NUM_GROUPS-1:0] enc_q;

  // Received message decode.
  logic rx_start_req, rx_deg_req, rx_end_req;
  logic rx_start_resp, rx_deg_resp, rx_end_resp;
  always_comb begin
    rx_start_req  = bus.i_sideband_valid && (bus.i_sideband_message == M_START_REQ);
    rx_start_resp = bus.i_sideband_valid && (bus.i_sideband_message == M_START_RESP);
    rx_deg_req    = bus.i_sideband_valid && (bus.i_sideband_message == M_DEGRADE_REQ);
    rx_deg_resp   = bus.i_sideband_valid && (bus.i_sideband_message == M_DEGRADE_RESP);
    rx_end_req    = bus.i_sideband_valid && (bus.i_sideband_message == M_END_REQ);
    rx_end_resp   = bus.i_sideband_valid && (bus.i_sideband_message == M_END_RESP);
  end

  // A request arriving this cycle already competes in arbitration, so a remote REQ
  // colliding with a ready local request gets its response out first.
  logic start_pend_eff, deg_pend_eff, end_pend_eff;
  assign start_pend_eff = start_pend_q | rx_start_req;
  assign deg_pend_eff   = deg_pend_q   | rx_deg_req;
  assign end_pend_eff   = end_pend_q   | rx_end_req;

  // Local request currently offered by the TX FSM.
  logic                  tx_req;
  logic [MSG_W-1:0]      tx_msg;
  logic [NUM_GROUPS-1:0] tx_enc;
  always_comb begin
    tx_req = 1'b0;
    tx_msg = '0;
    tx_enc = '0;
    case (state_q)
      S_SEND_START: begin tx_req = 1'b1; tx_msg = M_START_REQ; end
      S_SEND_DEG:   begin tx_req = 1'b1; tx_msg = M_DEGRADE_REQ; tx_enc = local_q; end
      S_SEND_END:   begin tx_req = 1'b1; tx_msg = M_END_REQ; end
      default:      ;
    endcase
  end

  // Issue arbitration: busy falling in the same cycle frees the port immediately.
  logic                  can_issue, issue;
  logic                  iss_start, iss_deg, iss_end, iss_tx;
  logic [MSG_W-1:0]      issue_msg;
  logic [NUM_GROUPS-1:0] issue_enc;
  always_comb begin
    can_issue = bus.i_en && (state_q != S_TIMEOUT) &&
                (!in_flight_q || bus.i_falling_edge_busy);
    issue     = 1'b0;
    iss_start = 1'b0;
    iss_deg   = 1'b0;
    iss_end   = 1'b0;
    iss_tx    = 1'b0;
    issue_msg = '0;
    issue_enc = '0;
    if (can_issue) begin
      if (start_pend_eff) begin
        issue = 1'b1; iss_start = 1'b1; issue_msg = M_START_RESP;
      end else if (deg_pend_eff) begin
        issue = 1'b1; iss_deg = 1'b1; issue_msg = M_DEGRADE_RESP;
      end else if (end_pend_eff) begin
        issue = 1'b1; iss_end = 1'b1; issue_msg = M_END_RESP;
      end else if (tx_req) begin
        issue = 1'b1; iss_tx = 1'b1; issue_msg = tx_msg; issue_enc = tx_enc;
      end
    end
  end

  // TX FSM next state.
  logic timer_hit;
  assign timer_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = S_SEND_START;
      S_SEND_START: if (iss_tx) state_d = S_WAIT_START;
      S_WAIT_START: if (rx_start_resp) state_d = S_SEND_DEG;
                    else if (timer_hit) state_d = S_TIMEOUT;
      S_SEND_DEG:   if (iss_tx) state_d = S_WAIT_DEG;
      S_WAIT_DEG:   if (rx_deg_resp) state_d = S_SEND_END;
                    else if (timer_hit) state_d = S_TIMEOUT;
      S_SEND_END:   if (iss_tx) state_d = S_WAIT_END;
      S_WAIT_END:   if (rx_end_resp) state_d = S_TX_DONE;
                    else if (timer_hit) state_d = S_TIMEOUT;
      S_TX_DONE:    state_d = S_TX_DONE;
      S_TIMEOUT:    state_d = S_TIMEOUT;
      default:      state_d = S_IDLE;
    endcase
    if (!bus.i_en) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath next values.
  logic in_wait;
  always_comb begin
    in_wait  = (state_q == S_WAIT_START) || (state_q == S_WAIT_DEG) || (state_q == S_WAIT_END);
    timer_d  = '0;
    if ((state_d == state_q) && in_wait) timer_d = timer_q + 1'b1;

    // A REQ seen in the cycle its earlier copy is answered re-arms the flag,
    // so the duplicate gets its own response.
    start_pend_d = (start_pend_q & ~iss_start) | (rx_start_req & ~(iss_start & ~start_pend_q));
    deg_pend_d   = (deg_pend_q   & ~iss_deg)   | (rx_deg_req   & ~(iss_deg   & ~deg_pend_q));
    end_pend_d   = (end_pend_q   & ~iss_end)   | (rx_end_req   & ~(iss_end   & ~end_pend_q));

    rx_done_d   = rx_done_q | iss_end;
    in_flight_d = issue ? 1'b1 : (bus.i_falling_edge_busy ? 1'b0 : in_flight_q);
    local_d     = (state_q == S_IDLE) ? bus.i_lanes_functional : local_q;
    remote_d    = rx_deg_req ? bus.i_sideband_data_lanes_encoding : remote_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      local_q      <= '0;
      remote_q     <= '0;
      start_pend_q <= 1'b0;
      deg_pend_q   <= 1'b0;
      end_pend_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      in_flight_q  <= 1'b0;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      msg_q        <= '0;
      enc_q        <= '0;
    end else if (!bus.i_en) begin
      local_q      <= '0;
      remote_q     <= '0;
      start_pend_q <= 1'b0;
      deg_pend_q   <= 1'b0;
      end_pend_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      in_flight_q  <= 1'b0;
      timer_q      <= '0;
      valid_q      <= 1'b0;
      msg_q        <= '0;
      enc_q        <= '0;
    end else begin
      local_q      <= local_d;
      remote_q     <= remote_d;
      start_pend_q <= start_pend_d;
      deg_pend_q   <= deg_pend_d;
      end_pend_q   <= end_pend_d;
      rx_done_q    <= rx_done_d;
      in_flight_q  <= in_flight_d;
      timer_q      <= timer_d;
      valid_q      <= issue;
      msg_q        <= issue_msg;
      enc_q        <= issue_enc;
    end
  end

  assign bus.o_valid                        = valid_q;
  assign bus.o_sideband_message             = msg_q;
  assign bus.o_sideband_data_lanes_encoding = enc_q;
  assign bus.o_remote_partner_lanes_result  = remote_q;
  assign bus.o_test_ack                     = (state_q == S_TX_DONE) && rx_done_q;
  assign bus.o_timeout                      = (state_q == S_TIMEOUT);

endmodule

// File: doc/repair_ctrl_ngroup.md
Name: repair_ctrl_ngroup

Overview:
- Parametrised MBTRAIN REPAIR handshake controller; successor to the fixed two-group (first/second 8 lanes) repair step.
- Runs the local requester and the remote responder roles in one block, sharing one sideband message port with internal arbitration.
- Handles NUM_GROUPS lane groups as a bitmask, adds a per-wait timeout, and latches the remote partner's functional-group mask for MBTRAIN.

Parameters:
- NUM_GROUPS, 2, number of lane groups; each encoding bit i = group i functional.
- TIMEOUT_CYCLES, 1000, maximum cycles spent in any wait state before timeout; must be ≥1.
- MSG_W, 4, sideband message code width.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  MBTRAIN enable; rising edge starts the step, low aborts it.
- i_lanes_functional  in  NUM_GROUPS  local functional-group mask.
- i_sideband_message  in  MSG_W  received message code.
- i_sideband_data_lanes_encoding  in  NUM_GROUPS  received group mask.
- i_sideband_valid  in  1  one-cycle strobe; received message and mask are valid.
- i_falling_edge_busy  in  1  pulse: sideband has consumed the last sent message.
- o_valid  out  1  one-cycle strobe qualifying the outgoing message.
- o_sideband_message  out  MSG_W  outgoing message code.
- o_sideband_data_lanes_encoding  out  NUM_GROUPS  outgoing group mask.
- o_remote_partner_lanes_result  out  NUM_GROUPS  remote functional-group mask, latched.
- o_test_ack  out  1  step complete (level).
- o_timeout  out  1  wait exceeded TIMEOUT_CYCLES (level).

Behaviour:
- Reset: all outputs 0, TX FSM in IDLE, all pending flags, timer and in-flight flag cleared. Reset is asynchronous.
- Message codes: 0 NONE, 1 START_REQ, 2 START_RESP, 3 DEGRADE_REQ, 4 DEGRADE_RESP, 5 END_REQ, 6 END_RESP. Any other code is ignored.
- i_en low: synchronously clear all state on the next clk. Outputs return to reset values one cycle later.

TX FSM (local requester):
- IDLE: on i_en high, latch i_lanes_functional, then go to SEND_START.
- SEND_START → WAIT_START_RESP → SEND_DEGRADE → WAIT_DEGRADE_RESP → SEND_END → WAIT_END_RESP → TX_DONE.
- SEND_x: leave when the message is issued (o_valid=1 for one cycle).
- WAIT_x: leave when the matching *_RESP is received.
- DEGRADE_REQ carries the latched local mask on o_sideband_data_lanes_encoding. All other messages carry 0.
- A local mask of all zeros is still sent unchanged.

RX side (remote responder):
- On receiving START_REQ, DEGRADE_REQ or END_REQ, set the matching pending-response flag.
- DEGRADE_REQ also latches i_sideband_data_lanes_encoding into o_remote_partner_lanes_result.
- Sending END_RESP sets rx_done.
- A duplicate REQ re-sets its flag; DEGRADE_REQ re-latches the mask and the response is re-sent.

Issue and arbitration:
- in_flight is set when o_valid is issued and cleared on i_falling_edge_busy.
- A message may issue only when in_flight=0.
- If in_flight is set and i_falling_edge_busy arrives in the same cycle, a new message may issue that same cycle.
- Priority: pending responses first (START_RESP > DEGRADE_RESP > END_RESP), then the TX request.
- At most one o_valid per cycle. A pending flag clears on issue.
- A receive in the same cycle as an issue is processed normally; no messages are dropped.

Timer:
- Counts every cycle in any WAIT_x state and resets on state change.
- When count == TIMEOUT_CYCLES: o_timeout=1, FSM holds in a TIMEOUT state, no further issues.
- o_timeout holds until i_en is low.

Completion:
- o_test_ack=1 when TX_DONE and rx_done are both set; holds until i_en is low.
- o_test_ack and o_timeout are mutually exclusive.

Test Plan:
- Nominal, NUM_GROUPS=2, local 2'b11, remote DEGRADE_REQ 2'b01:
  - Outputs in order START_REQ, START_RESP, DEGRADE_REQ enc 2'b11, DEGRADE_RESP, END_REQ, END_RESP.
  - o_remote_partner_lanes_result=2'b01; o_test_ack=1 after END_RESP is both sent and received.
- Collision: remote START_REQ arrives while local DEGRADE_REQ is ready and in_flight=0 → START_RESP issues first; DEGRADE_REQ issues after the next i_falling_edge_busy.
- Timeout, TIMEOUT_CYCLES=16: no START_RESP received → o_timeout=1 exactly 16 cycles after entering WAIT_START_RESP; no further o_valid; o_test_ack=0.
- Abort: i_en dropped in WAIT_DEGRADE_RESP → all outputs 0 within 2 cycles; next i_en rise restarts with START_REQ.
- NUM_GROUPS=4, local 4'b0000, remote 4'b1010 → DEGRADE_REQ enc 4'b0000 is sent; result latched as 4'b1010; completes with o_test_ack=1.
- Async reset asserted mid-handshake → all outputs 0 immediately, without waiting for clk.
